// File: rtl/sound_rom_arbiter_if.sv
// Bundle between the channel fetchers, the ROM read port and the sound ROM arbiter.
// The arbiter uses the master view; the fetchers and ROM use the slave view.
interface sound_rom_arbiter_if #(
  parameter int NUM_CH = 10,
  parameter int CH_W   = 4,
  parameter int ADDR_W = 24
);
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic                     rom_load;
  logic [ADDR_W-1:0]        rom_addr;
  logic [7:0]               rom_data;
  logic                     rom_ready;
  logic                     rd_valid;
  logic [7:0]               rd_data;
  logic [CH_W-1:0]          rd_ch;
  logic                     busy;
  logic                     clr_err;
  logic                     timeout_err;

  modport master (
    input  req, req_addr, rom_data, rom_ready, clr_err,
    output rom_load, rom_addr, rd_valid, rd_data, rd_ch, busy, timeout_err
  );

  modport slave (
    output req, req_addr, rom_data, rom_ready, clr_err,
    input  rom_load, rom_addr, rd_valid, rd_data, rd_ch, busy, timeout_err
  );
endinterface

// File: rtl/sound_rom_arbiter.sv
// Round-robin sharing of the byte-wide sample ROM between the sound channel fetchers:
// load strobe, bounded wait for ready, then a one-cycle tagged data return.
module sound_rom_arbiter #(
  parameter int NUM_CH  = 10,
  parameter int CH_W    = 4,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  sound_rom_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [CH_W-1:0]   ptr_r;
  logic [CH_W-1:0]   ch_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              rom_load_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              rd_valid_r;
  logic [7:0]        rd_data_r;
  logic [CH_W-1:0]   rd_ch_r;
  logic              busy_r;
  logic              timeout_err_r;

  logic [NUM_CH-1:0] upper_s;
  logic [NUM_CH-1:0] pick_s;
  logic              any_s;
  logic [CH_W-1:0]   winner_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [CH_W-1:0]   next_ptr_s;
  logic              timeout_hit_s;

  // Round-robin winner: lowest request at or above ptr, else lowest request overall
  always_comb begin
    upper_s = bus.req & ({NUM_CH{1'b1}} << ptr_r);
    if (|upper_s) begin
      pick_s = upper_s;
    end else begin
      pick_s = bus.req;
    end
    any_s    = |bus.req;
    winner_s = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pick_s[i]) begin
        winner_s = CH_W'(i);
      end else begin
        winner_s = winner_s;
      end
    end
    win_addr_s = bus.req_addr[winner_s*ADDR_W +: ADDR_W];
  end

  // Pointer wrap is at NUM_CH, and the timeout fires only on a WAIT cycle without ready
  always_comb begin
    if (ch_r == CH_W'(NUM_CH - 1)) begin
      next_ptr_s = {CH_W{1'b0}};
    end else begin
      next_ptr_s = ch_r + CH_W'(1);
    end
    timeout_hit_s = (state_r == ST_WAIT) && !bus.rom_ready &&
                    (cnt_r == CNT_W'(TIMEOUT - 1));
  end

  // Access sequencer; every output is registered and rom_ready is honoured only in WAIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {CH_W{1'b0}};
      ch_r       <= {CH_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      rom_load_r <= 1'b0;
      rom_addr_r <= {ADDR_W{1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= 8'h00;
      rd_ch_r    <= {CH_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            ch_r       <= winner_s;
            rom_addr_r <= win_addr_s;
            rom_load_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rom_load_r <= 1'b0;
          cnt_r      <= {CNT_W{1'b0}};
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.rom_ready) begin
            rd_data_r  <= bus.rom_data;
            rd_ch_r    <= ch_r;
            rd_valid_r <= 1'b1;
            state_r    <= ST_DONE;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            rd_data_r  <= 8'h00;
            rd_ch_r    <= ch_r;
            rd_valid_r <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          rd_valid_r <= 1'b0;
          ptr_r      <= next_ptr_s;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          rom_load_r <= 1'b0;
          rd_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a new timeout outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end else if (bus.clr_err) begin
      timeout_err_r <= 1'b0;
    end
  end

  assign bus.rom_load    = rom_load_r;
  assign bus.rom_addr    = rom_addr_r;
  assign bus.rd_valid    = rd_valid_r;
  assign bus.rd_data     = rd_data_r;
  assign bus.rd_ch       = rd_ch_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;

endmodule
